// File: rtl/jk_updown_counter_pkg.sv
// ---------------------------------------------------------------------------
// jk_updown_counter_pkg : shared direction and JK-encoding constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package jk_updown_counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // {J,K} input encodings
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/jk_updown_counter_jk_ff.sv
// ---------------------------------------------------------------------------
// jk_ff : single JK flip-flop, asynchronous active-high reset to Q=0
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jk_ff
  import jk_updown_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TOG:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/jk_updown_counter.sv
// ---------------------------------------------------------------------------
// jk_updown_counter : modulo-N up/down counter built from JK flip-flops
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jk_updown_counter
  import jk_updown_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             at_max;
  logic             at_zero;
  logic             out_of_range;

  assign at_max       = (count == MAX_CNT);
  assign at_zero      = (count == '0);
  assign out_of_range = (int'(count) >= MODULUS);

  always_comb begin
    nxt = count;
    if (load) begin
      nxt = (int'(load_val) >= MODULUS) ? MAX_CNT : load_val;
    end else if (en) begin
      if (out_of_range) begin
        nxt = '0;
      end else if (dir == DIR_UP) begin
        nxt = at_max ? '0 : count + WIDTH'(1);
      end else begin
        nxt = at_zero ? MAX_CNT : count - WIDTH'(1);
      end
    end
  end

  // An out-of-range count matches neither endpoint, so tc stays low there.
  assign tc = en & ~load &
              (((dir == DIR_UP) & at_max) | ((dir == DIR_DOWN) & at_zero));

  // Set bits that must rise, reset bits that must fall, hold the rest.
  assign j = nxt & ~count;
  assign k = ~nxt & count;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_ff u_ff (
        .clk (clk),
        .rst (rst),
        .j   (j[i]),
        .k   (k[i]),
        .q   (count[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jk_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_updown_counter : scoreboard bench for three counter configurations
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jk_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] lv4;

  logic [3:0] cnt16, cnt10;
  logic [1:0] cnt2;
  logic       tc16, tc10, tc2;
  logic       wr16, wr10, wr2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jk_updown_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv4),
    .count(cnt16), .tc(tc16), .wrap(wr16));

  jk_updown_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv4),
    .count(cnt10), .tc(tc10), .wrap(wr10));

  jk_updown_counter #(.WIDTH(2), .MODULUS(2)) u_m2 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv4[1:0]),
    .count(cnt2), .tc(tc2), .wrap(wr2));

  typedef struct packed {
    logic [2:0]  tc;
    logic [2:0]  wr;
    logic [11:0] cnt;
  } exp_t;

  exp_t q[$];

  // Reference model state: the count each instance should hold
  int mc[3];
  int mods[3]  = '{16, 10, 2};
  int wmask[3] = '{15, 15, 3};

  function automatic int act_cnt(int i);
    case (i)
      0:       return int'(cnt16);
      1:       return int'(cnt10);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic int act_tc(int i);
    case (i)
      0:       return int'(tc16);
      1:       return int'(tc10);
      default: return int'(tc2);
    endcase
  endfunction

  function automatic int act_wr(int i);
    case (i)
      0:       return int'(wr16);
      1:       return int'(wr10);
      default: return int'(wr2);
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and push what the next edge should produce.
  task automatic drive(bit e, bit d, bit l, int v);
    exp_t x;
    x = '0;
    @(negedge clk);
    en   = e;
    dir  = d;
    load = l;
    lv4  = 4'(v);
    for (int i = 0; i < 3; i++) begin
      int  lvi;
      int  m;
      bit  t;
      lvi = v & wmask[i];
      m   = mods[i];
      t   = e && !l && ((!d && mc[i] == m - 1) || (d && mc[i] == 0));
      x.tc[i] = t;
      x.wr[i] = t;
      if (l)                mc[i] = (lvi >= m) ? m - 1 : lvi;
      else if (e) begin
        if (mc[i] >= m)     mc[i] = 0;
        else if (!d)        mc[i] = (mc[i] + 1) % m;
        else                mc[i] = (mc[i] + m - 1) % m;
      end
      x.cnt[4*i +: 4] = 4'(mc[i]);
    end
    q.push_back(x);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: tc checked just before the edge, count/wrap just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 3; i++)
          chk($sformatf("tc[%0d]", i), act_tc(i), int'(e.tc[i]));
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("count[%0d]", i), act_cnt(i), int'(e.cnt[4*i +: 4]));
          chk($sformatf("wrap[%0d]", i), act_wr(i), int'(e.wr[i]));
        end
      end
    end
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    dir  = 1'b0;
    load = 1'b0;
    lv4  = 4'd0;
    for (int i = 0; i < 3; i++) mc[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", int'(cnt16), 0);
    chk("reset_wrap", int'(wr16), 0);
    chk("reset_tc", int'(tc16), 0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-cycle from count=9, then resume counting up
    drive(0, 0, 1, 9);
    settle();
    chk("preload_9", int'(cnt16), 9);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_cnt16", int'(cnt16), 0);
    chk("async_rst_cnt10", int'(cnt10), 0);
    chk("async_rst_wrap", int'(wr16), 0);
    for (int i = 0; i < 3; i++) mc[i] = 0;
    rst = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      drive(1, 0, 0, 0);
      settle();
      chk("resume_up", int'(cnt16), n);
    end

    // Up wrap with default modulus
    drive(0, 0, 1, 0);
    repeat (15) drive(1, 0, 0, 0);
    settle();
    chk("up_at_15", int'(cnt16), 15);
    chk("up_tc_15", int'(tc16), 1);
    drive(1, 0, 0, 0);
    settle();
    chk("up_wrap_cnt", int'(cnt16), 0);
    chk("up_wrap_pulse", int'(wr16), 1);
    drive(0, 0, 0, 0);
    settle();
    chk("up_wrap_one_cycle", int'(wr16), 0);

    // Down wrap, modulus 10
    drive(0, 0, 1, 2);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    settle();
    chk("down_at_0", int'(cnt10), 0);
    chk("down_tc_0", int'(tc10), 1);
    drive(1, 1, 0, 0);
    settle();
    chk("down_wrap_9", int'(cnt10), 9);
    chk("down_wrap_pulse", int'(wr10), 1);
    drive(1, 1, 0, 0);
    settle();
    chk("down_8", int'(cnt10), 8);

    // Load priority and saturation
    drive(0, 0, 1, 5);
    drive(1, 1, 1, 12);
    settle();
    chk("load_12_m16", int'(cnt16), 12);
    chk("load_sat_m10", int'(cnt10), 9);
    chk("load_wrap0", int'(wr10), 0);

    // Direction flip, then hold
    drive(0, 0, 1, 3);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    settle();
    chk("flip_back_3", int'(cnt16), 3);
    repeat (4) drive(0, 1, 0, 0);
    settle();
    chk("hold_3", int'(cnt16), 3);
    chk("hold_tc", int'(tc16), 0);

    // Modulus 2 continuous up
    drive(0, 0, 1, 0);
    repeat (4) drive(1, 0, 0, 0);
    settle();
    chk("m2_count", int'(cnt2), 0);
    chk("m2_wrap", int'(wr2), 1);

    // Random traffic against the model
    for (int n = 0; n < 1000; n++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0, int'($urandom_range(0, 15)));
    end
    drive(0, 0, 0, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
